// File: rtl/retrosoc_pad_ctrl.sv
// Pad-control block between the SoC core and the tri-state pad ring.
// Per pad it provides a function mux, a 2-flop input sync, an optional debounce filter and edge interrupts.
module retrosoc_pad_ctrl #(
  parameter int PAD_NUM = 16,
  parameter int ALT_NUM = 2,
  parameter int DEB_W   = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic                       mem_valid_i,
  input  logic [7:0]                 mem_addr_i,
  input  logic [31:0]                mem_wdata_i,
  input  logic [3:0]                 mem_wstrb_i,
  output logic [31:0]                mem_rdata_o,
  output logic                       mem_ready_o,
  input  logic [PAD_NUM*ALT_NUM-1:0] alt_out_i,
  input  logic [PAD_NUM*ALT_NUM-1:0] alt_oe_i,
  output logic [PAD_NUM-1:0]         alt_in_o,
  output logic [PAD_NUM-1:0]         pad_c2p_o,
  output logic [PAD_NUM-1:0]         pad_c2p_en_o,
  input  logic [PAD_NUM-1:0]         pad_p2c_i,
  output logic                       irq_o
);

  localparam logic [5:0] A_OUT    = 6'h00;
  localparam logic [5:0] A_OE     = 6'h01;
  localparam logic [5:0] A_IN     = 6'h02;
  localparam logic [5:0] A_FSEL0  = 6'h03;
  localparam logic [5:0] A_FSEL1  = 6'h04;
  localparam logic [5:0] A_DEBEN  = 6'h05;
  localparam logic [5:0] A_DEBDIV = 6'h06;
  localparam logic [5:0] A_RISE   = 6'h07;
  localparam logic [5:0] A_FALL   = 6'h08;
  localparam logic [5:0] A_STAT   = 6'h09;

  typedef logic [PAD_NUM-1:0] pads_t;

  pads_t out_q, out_d, oe_q, oe_d, deb_en_q, deb_en_d;
  pads_t rise_en_q, rise_en_d, fall_en_q, fall_en_d, stat_q, stat_d, stat_clr, edge_ev;
  pads_t sync1_q, sync2_q, filt_q, filt_d, filt_dly_q;
  logic [2*PAD_NUM-1:0]    fsel_q, fsel_d;
  logic [63:0]             fsel_ext;
  logic [PAD_NUM-1:0][1:0] cnt_q, cnt_d;
  logic [DEB_W-1:0]        div_q, div_d, pre_q, pre_d;
  logic                    ready_q, irq_q, tick, acc, wr;
  logic [31:0]             rdata_q, rd, wmask;
  logic [5:0]              widx;
  logic                    addr_unused;

  function automatic pads_t merge_pads(input pads_t old, input logic [31:0] wd, input logic [31:0] m);
    for (int i = 0; i < PAD_NUM; i++) merge_pads[i] = m[i] ? wd[i] : old[i];
  endfunction

  function automatic logic [31:0] zext_pads(input pads_t v);
    zext_pads = '0;
    zext_pads[PAD_NUM-1:0] = v;
  endfunction

  assign acc         = mem_valid_i & ~ready_q;
  assign wr          = acc & (mem_wstrb_i != 4'b0000);
  assign widx        = mem_addr_i[7:2];
  assign addr_unused = ^mem_addr_i[1:0];
  assign wmask       = {{8{mem_wstrb_i[3]}}, {8{mem_wstrb_i[2]}}, {8{mem_wstrb_i[1]}}, {8{mem_wstrb_i[0]}}};

  always_comb begin
    out_d     = out_q;
    oe_d      = oe_q;
    fsel_d    = fsel_q;
    deb_en_d  = deb_en_q;
    div_d     = div_q;
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    stat_clr  = '0;
    if (wr) begin
      case (widx)
        A_OUT:    out_d     = merge_pads(out_q, mem_wdata_i, wmask);
        A_OE:     oe_d      = merge_pads(oe_q, mem_wdata_i, wmask);
        A_DEBEN:  deb_en_d  = merge_pads(deb_en_q, mem_wdata_i, wmask);
        A_RISE:   rise_en_d = merge_pads(rise_en_q, mem_wdata_i, wmask);
        A_FALL:   fall_en_d = merge_pads(fall_en_q, mem_wdata_i, wmask);
        A_STAT:   stat_clr  = merge_pads('0, mem_wdata_i, wmask);
        A_DEBDIV: for (int i = 0; i < DEB_W; i++) div_d[i] = wmask[i] ? mem_wdata_i[i] : div_q[i];
        default: ;
      endcase
      // Pads 0-15 live in FSEL0, pads 16-31 in FSEL1, two bits each.
      for (int p = 0; p < PAD_NUM; p++) begin
        if (widx == ((p < 16) ? A_FSEL0 : A_FSEL1)) begin
          for (int b = 0; b < 2; b++)
            fsel_d[2*p+b] = wmask[2*(p%16)+b] ? mem_wdata_i[2*(p%16)+b] : fsel_q[2*p+b];
        end
      end
    end
  end

  always_comb begin
    tick   = (pre_q == '0);
    pre_d  = (wr && widx == A_DEBDIV) ? '0 : (tick ? div_q : pre_q - DEB_W'(1));
    filt_d = filt_q;
    cnt_d  = cnt_q;
    for (int p = 0; p < PAD_NUM; p++) begin
      if (!deb_en_q[p]) begin
        filt_d[p] = sync2_q[p];
        cnt_d[p]  = 2'd0;
      end else if (tick) begin
        if (sync2_q[p] == filt_q[p]) begin
          cnt_d[p] = 2'd0;
        end else if (cnt_q[p] == 2'd3) begin
          filt_d[p] = sync2_q[p];
          cnt_d[p]  = 2'd0;
        end else begin
          cnt_d[p] = cnt_q[p] + 2'd1;
        end
      end
      if (!deb_en_d[p]) cnt_d[p] = 2'd0;
    end
    edge_ev = (filt_q & ~filt_dly_q & rise_en_q) | (~filt_q & filt_dly_q & fall_en_q);
    // A new edge in the same cycle as its W1C clear keeps the bit set.
    stat_d  = (stat_q & ~stat_clr) | edge_ev;
  end

  always_comb begin
    rd       = '0;
    fsel_ext = '0;
    fsel_ext[2*PAD_NUM-1:0] = fsel_q;
    case (widx)
      A_OUT:    rd = zext_pads(out_q);
      A_OE:     rd = zext_pads(oe_q);
      A_IN:     rd = zext_pads(filt_q);
      A_FSEL0:  rd = fsel_ext[31:0];
      A_FSEL1:  rd = fsel_ext[63:32];
      A_DEBEN:  rd = zext_pads(deb_en_q);
      A_DEBDIV: rd[DEB_W-1:0] = div_q;
      A_RISE:   rd = zext_pads(rise_en_q);
      A_FALL:   rd = zext_pads(fall_en_q);
      A_STAT:   rd = zext_pads(stat_q);
      default:  rd = '0;
    endcase
  end

  always_comb begin
    pad_c2p_o    = '0;
    pad_c2p_en_o = '0;
    for (int p = 0; p < PAD_NUM; p++) begin
      if (fsel_q[2*p +: 2] == 2'd0) begin
        pad_c2p_o[p]    = out_q[p];
        pad_c2p_en_o[p] = oe_q[p];
      end
      for (int k = 0; k < ALT_NUM; k++) begin
        if (fsel_q[2*p +: 2] == 2'(k + 1)) begin
          pad_c2p_o[p]    = alt_out_i[k*PAD_NUM+p];
          pad_c2p_en_o[p] = alt_oe_i[k*PAD_NUM+p];
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      out_q      <= '0;
      oe_q       <= '0;
      fsel_q     <= '0;
      deb_en_q   <= '0;
      div_q      <= '0;
      rise_en_q  <= '0;
      fall_en_q  <= '0;
      stat_q     <= '0;
      sync1_q    <= '0;
      sync2_q    <= '0;
      filt_q     <= '0;
      filt_dly_q <= '0;
      cnt_q      <= '0;
      pre_q      <= '0;
      ready_q    <= 1'b0;
      rdata_q    <= '0;
      irq_q      <= 1'b0;
    end else begin
      out_q      <= out_d;
      oe_q       <= oe_d;
      fsel_q     <= fsel_d;
      deb_en_q   <= deb_en_d;
      div_q      <= div_d;
      rise_en_q  <= rise_en_d;
      fall_en_q  <= fall_en_d;
      stat_q     <= stat_d;
      sync1_q    <= pad_p2c_i;
      sync2_q    <= sync1_q;
      filt_q     <= filt_d;
      filt_dly_q <= filt_q;
      cnt_q      <= cnt_d;
      pre_q      <= pre_d;
      ready_q    <= acc;
      rdata_q    <= acc ? rd : '0;
      irq_q      <= |stat_q;
    end
  end

  assign mem_ready_o = ready_q;
  assign mem_rdata_o = rdata_q;
  assign alt_in_o    = filt_q;
  assign irq_o       = irq_q;

endmodule

// File: tb/tb_retrosoc_pad_ctrl.sv
// Bench for retrosoc_pad_ctrl: per-cycle comparison against a register/timing model plus directed literal checks.
module tb_retrosoc_pad_ctrl;
  localparam int PN = 16;
  localparam int AN = 2;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic mem_valid = 1'b0;
  logic [7:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic [3:0] mem_wstrb = '0;
  logic [31:0] mem_rdata;
  logic mem_ready;
  logic [PN*AN-1:0] alt_out = '0;
  logic [PN*AN-1:0] alt_oe = '0;
  logic [PN-1:0] alt_in, pad_c2p, pad_c2p_en;
  logic [PN-1:0] pad_p2c = '0;
  logic irq;

  always #5 clk = ~clk;

  retrosoc_pad_ctrl #(.PAD_NUM(PN), .ALT_NUM(AN), .DEB_W(DW)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .mem_valid_i(mem_valid), .mem_addr_i(mem_addr), .mem_wdata_i(mem_wdata), .mem_wstrb_i(mem_wstrb),
    .mem_rdata_o(mem_rdata), .mem_ready_o(mem_ready),
    .alt_out_i(alt_out), .alt_oe_i(alt_oe), .alt_in_o(alt_in),
    .pad_c2p_o(pad_c2p), .pad_c2p_en_o(pad_c2p_en), .pad_p2c_i(pad_p2c), .irq_o(irq)
  );

  int n_chk = 0;
  int n_fail = 0;
  bit run = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] smask(input logic [3:0] s);
    return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
  endfunction

  // Model state: registers as the software sees them, plus filter/interrupt bookkeeping.
  logic [15:0] m_out = '0, m_oe = '0, m_deb = '0, m_rise = '0, m_fall = '0, m_stat = '0;
  logic [15:0] m_filt = '0, m_dly = '0, h1 = '0, h2 = '0, nf, set_v, clr_v;
  logic [31:0] m_fsel = '0, m_rdata = '0, rdv, msk;
  logic [7:0]  m_div = '0;
  logic        m_ready = 1'b0, m_irq = 1'b0, acc, we, tick;
  int          m_cnt [16];
  int          m_edge = 0, m_last_clr = 0, n;
  logic        s_v;
  logic [7:0]  s_a;
  logic [31:0] s_wd;
  logic [3:0]  s_ws;
  logic [15:0] s_p, e_c2p, e_en;
  logic [1:0]  sel;

  initial for (int i = 0; i < 16; i++) m_cnt[i] = 0;

  always @(posedge clk) begin
    if (run) begin
      s_v = mem_valid; s_a = mem_addr; s_wd = mem_wdata; s_ws = mem_wstrb; s_p = pad_p2c;
      acc = s_v && !m_ready;
      we  = acc && (s_ws != 4'b0);
      msk = smask(s_ws);
      n   = m_edge + 1;
      // Filter ticks fall every DEB_DIV+1 cycles, counted from reset or the last DEB_DIV write.
      tick = ((n - m_last_clr - 1) % (int'(m_div) + 1)) == 0;
      case (s_a[7:2])
        6'd0: rdv = {16'h0, m_out};
        6'd1: rdv = {16'h0, m_oe};
        6'd2: rdv = {16'h0, m_filt};
        6'd3: rdv = m_fsel;
        6'd5: rdv = {16'h0, m_deb};
        6'd6: rdv = {24'h0, m_div};
        6'd7: rdv = {16'h0, m_rise};
        6'd8: rdv = {16'h0, m_fall};
        6'd9: rdv = {16'h0, m_stat};
        default: rdv = '0;
      endcase
      set_v = (m_filt & ~m_dly & m_rise) | (~m_filt & m_dly & m_fall);
      nf = m_filt;
      for (int p = 0; p < 16; p++) begin
        if (!m_deb[p]) nf[p] = h2[p];
        else if (tick) begin
          if (h2[p] != m_filt[p]) begin
            if (m_cnt[p] == 3) begin nf[p] = h2[p]; m_cnt[p] = 0; end
            else m_cnt[p] = m_cnt[p] + 1;
          end else m_cnt[p] = 0;
        end
      end
      m_irq  = |m_stat;
      m_dly  = m_filt;
      m_filt = nf;
      clr_v  = (we && s_a[7:2] == 6'd9) ? (s_wd[15:0] & msk[15:0]) : 16'h0;
      m_stat = (m_stat & ~clr_v) | set_v;
      if (we) begin
        case (s_a[7:2])
          6'd0: m_out  = (m_out  & ~msk[15:0]) | (s_wd[15:0] & msk[15:0]);
          6'd1: m_oe   = (m_oe   & ~msk[15:0]) | (s_wd[15:0] & msk[15:0]);
          6'd3: m_fsel = (m_fsel & ~msk) | (s_wd & msk);
          6'd5: begin
            m_deb = (m_deb & ~msk[15:0]) | (s_wd[15:0] & msk[15:0]);
            for (int p = 0; p < 16; p++) if (!m_deb[p]) m_cnt[p] = 0;
          end
          6'd6: begin m_div = (m_div & ~msk[7:0]) | (s_wd[7:0] & msk[7:0]); m_last_clr = n; end
          6'd7: m_rise = (m_rise & ~msk[15:0]) | (s_wd[15:0] & msk[15:0]);
          6'd8: m_fall = (m_fall & ~msk[15:0]) | (s_wd[15:0] & msk[15:0]);
          default: ;
        endcase
      end
      h2 = h1; h1 = s_p;
      m_ready = acc;
      m_rdata = acc ? rdv : 32'h0;
      m_edge  = n;
      #1;
      for (int p = 0; p < 16; p++) begin
        sel = m_fsel[2*p +: 2];
        if (sel == 2'd0) begin e_c2p[p] = m_out[p]; e_en[p] = m_oe[p]; end
        else if (int'(sel) <= AN) begin
          e_c2p[p] = alt_out[(int'(sel)-1)*PN+p]; e_en[p] = alt_oe[(int'(sel)-1)*PN+p];
        end else begin e_c2p[p] = 1'b0; e_en[p] = 1'b0; end
      end
      chk("cyc_ready", 32'(mem_ready), 32'(m_ready));
      chk("cyc_rdata", mem_rdata, m_rdata);
      chk("cyc_in", 32'(alt_in), 32'(m_filt));
      chk("cyc_c2p", 32'(pad_c2p), 32'(e_c2p));
      chk("cyc_c2p_en", 32'(pad_c2p_en), 32'(e_en));
      chk("cyc_irq", 32'(irq), 32'(m_irq));
    end
  end

  task automatic bus(input logic [7:0] a, input logic [31:0] wd, input logic [3:0] ws, output logic [31:0] rd);
    int cyc;
    mem_valid = 1'b1; mem_addr = a; mem_wdata = wd; mem_wstrb = ws;
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!mem_ready && cyc < 20);
    chk("ready_latency", 32'(cyc), 32'd1);
    rd = mem_rdata;
    mem_valid = 1'b0; mem_wstrb = 4'b0;
    @(negedge clk);
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] wd);
    logic [31:0] dummy;
    bus(a, wd, 4'hF, dummy);
  endtask

  logic [31:0] rv;

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1; run = 1'b1;
    chk("rst_c2p_en", 32'(pad_c2p_en), 32'h0);
    chk("rst_c2p", 32'(pad_c2p), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    for (int a = 0; a <= 'h24; a += 4) begin
      bus(8'(a), 32'h0, 4'h0, rv);
      chk("rst_read", rv, 32'h0);
    end

    alt_out = {16'hFFFF, 16'h0000};
    alt_oe  = {16'h0F02, 16'h00F2};
    wr(8'h04, 32'hFFFF_FFFF);
    bus(8'h04, 32'h0, 4'h0, rv);
    chk("oe_upper_bits", rv, 32'h0000_FFFF);
    wr(8'h00, 32'h0000_A5A5);
    chk("gpio_c2p", 32'(pad_c2p), 32'h0000_A5A5);
    chk("gpio_en", 32'(pad_c2p_en), 32'h0000_FFFF);
    wr(8'h0C, 32'h4);
    chk("alt1_c2p", 32'(pad_c2p), 32'h0000_A5A5);
    chk("alt1_en", 32'(pad_c2p_en), 32'h0000_FFFF);
    wr(8'h0C, 32'h8);
    chk("alt2_c2p", 32'(pad_c2p), 32'h0000_A5A7);
    wr(8'h0C, 32'hC);
    chk("fsel3_c2p", 32'(pad_c2p), 32'h0000_A5A5);
    chk("fsel3_en", 32'(pad_c2p_en), 32'h0000_FFFD);
    wr(8'h0C, 32'hE4E4_0000);
    wr(8'h10, 32'hFFFF_FFFF);
    bus(8'h10, 32'h0, 4'h0, rv);
    chk("fsel1_read", rv, 32'h0);
    wr(8'h0C, 32'h0);

    wr(8'h1C, 32'h8);
    pad_p2c[3] = 1'b1;
    repeat (2) @(negedge clk);
    chk("in3_lat2", 32'(alt_in[3]), 32'h0);
    @(negedge clk);
    chk("in3_lat3", 32'(alt_in[3]), 32'h1);
    @(negedge clk);
    chk("irq_before", 32'(irq), 32'h0);
    @(negedge clk);
    chk("irq_after", 32'(irq), 32'h1);
    bus(8'h24, 32'h0, 4'h0, rv);
    chk("stat_rise", rv, 32'h8);
    wr(8'h24, 32'h8);
    chk("irq_cleared", 32'(irq), 32'h0);
    bus(8'h24, 32'h0, 4'h0, rv);
    chk("stat_cleared", rv, 32'h0);

    wr(8'h20, 32'h8);
    pad_p2c[3] = 1'b0;
    repeat (3) @(negedge clk);
    wr(8'h24, 32'h8);
    bus(8'h24, 32'h0, 4'h0, rv);
    chk("stat_set_wins", rv, 32'h8);
    wr(8'h24, 32'hFFFF_FFFF);

    wr(8'h14, 32'h20);
    wr(8'h18, 32'h9);
    pad_p2c[5] = 1'b1;
    repeat (25) @(negedge clk);
    pad_p2c[5] = 1'b0;
    repeat (60) @(negedge clk);
    chk("deb_glitch", 32'(alt_in[5]), 32'h0);
    pad_p2c[5] = 1'b1;
    repeat (60) @(negedge clk);
    chk("deb_pass", 32'(alt_in[5]), 32'h1);
    pad_p2c = 16'h3C5A;
    repeat (20) @(negedge clk);
    wr(8'h14, 32'h0);
    repeat (5) @(negedge clk);

    wr(8'h00, 32'h0);
    bus(8'h00, 32'hFFFF_FFFF, 4'b0001, rv);
    bus(8'h00, 32'h0, 4'h0, rv);
    chk("wstrb_out", rv, 32'h0000_00FF);
    bus(8'h3C, 32'h0, 4'h0, rv);
    chk("unmapped_read", rv, 32'h0);
    wr(8'h3C, 32'hDEAD_BEEF);
    repeat (3) @(negedge clk);

    run = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
